// File: rtl/kv_entry_allocator.sv
// kv_entry_allocator: N-entry holding buffer, lowest-free-slot allocation, masked release
module kv_entry_allocator #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM = 4,
  localparam int IDX_WIDTH = $clog2(DATA_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [IDX_WIDTH-1:0]  o_wr_idx,
  input  logic [DATA_NUM-1:0]   i_release,
  output logic [DATA_WIDTH-1:0] o_datas [DATA_NUM-1:0],
  output logic [DATA_NUM-1:0]   o_valid,
  output logic [IDX_WIDTH:0]    o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  logic [DATA_NUM-1:0]   r_valid, w_valid_next, w_rel;
  logic [DATA_WIDTH-1:0] r_datas [DATA_NUM-1:0];
  logic [IDX_WIDTH:0]    r_count, w_count_next;
  logic                  r_full, r_empty, w_accept;
  logic [IDX_WIDTH-1:0]  w_idx;
  // lowest free slot from the registered valid bits; 0 when nothing is free
  always_comb begin
    w_idx = '0;
    for (int i = DATA_NUM - 1; i >= 0; i--) if (!r_valid[i]) w_idx = IDX_WIDTH'(i);
  end
  assign o_wr_ready = !r_full && !i_flush;
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_rel      = i_release & r_valid;
  // next occupancy: flush wins, else releases cleared and the new slot set (never the same slot)
  always_comb begin
    w_valid_next = i_flush ? '0 : (r_valid & ~w_rel) | (w_accept ? DATA_NUM'(1) << w_idx : '0);
    w_count_next = (IDX_WIDTH + 1)'($countones(w_valid_next));
  end
  // occupancy and status flags, all registered from the same next-state vector
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
      r_full  <= w_count_next == (IDX_WIDTH + 1)'(DATA_NUM);
      r_empty <= w_count_next == '0;
    end
  // entry storage; released or flushed entries keep stale data
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < DATA_NUM; i++) r_datas[i] <= '0;
    else if (w_accept) r_datas[w_idx] <= i_wr_data;
  assign o_wr_idx = w_idx;
  assign o_datas  = r_datas;
  assign o_valid  = r_valid;
  assign o_count  = r_count;
  assign o_full   = r_full;
  assign o_empty  = r_empty;
endmodule

// File: tb/tb_kv_entry_allocator.sv
// tb_kv_entry_allocator: directed table, corner sequences and randomized model check
module tb_kv_entry_allocator;
  localparam int N = 4;
  logic i_clk = 0, i_rst_n = 0, i_flush = 0, i_wr_valid = 0;
  logic [31:0] i_wr_data = '0;
  logic [N-1:0] i_release = '0;
  logic o_wr_ready, o_full, o_empty;
  logic [1:0] o_wr_idx;
  logic [31:0] o_datas [N-1:0];
  logic [N-1:0] o_valid;
  logic [2:0] o_count;
  int n_tests = 0, n_fail = 0;

  kv_entry_allocator #(.DATA_WIDTH(32), .DATA_NUM(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data), .o_wr_idx(o_wr_idx),
    .i_release(i_release), .o_datas(o_datas), .o_valid(o_valid), .o_count(o_count),
    .o_full(o_full), .o_empty(o_empty));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic fl; logic wv; logic [31:0] d; logic [3:0] rel;
    logic [3:0] ev; int ec; int ei; logic er;
    logic cd; int cs; logic [31:0] ed;
  } vec_t;
  vec_t vecs[14];

  logic [N-1:0] m_valid;
  logic [31:0] m_data [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic int m_idx();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  task automatic idle();
    i_flush = 0; i_wr_valid = 0; i_release = '0;
  endtask

  initial begin
    vecs[0]  = '{0, 1, 32'h0000_0000, 4'b0000, 4'b0001, 1, 1, 1, 1, 0, 32'h0000_0000};
    vecs[1]  = '{0, 1, 32'h0000_ffff, 4'b0000, 4'b0011, 2, 2, 1, 1, 1, 32'h0000_ffff};
    vecs[2]  = '{0, 1, 32'hffff_0000, 4'b0000, 4'b0111, 3, 3, 1, 1, 2, 32'hffff_0000};
    vecs[3]  = '{0, 1, 32'hffff_ffff, 4'b0000, 4'b1111, 4, 0, 0, 1, 3, 32'hffff_ffff};
    vecs[4]  = '{0, 1, 32'hdead_beef, 4'b0000, 4'b1111, 4, 0, 0, 1, 0, 32'h0000_0000};
    vecs[5]  = '{0, 1, 32'hdead_beef, 4'b0000, 4'b1111, 4, 0, 0, 1, 1, 32'h0000_ffff};
    vecs[6]  = '{0, 1, 32'hdead_beef, 4'b0000, 4'b1111, 4, 0, 0, 1, 3, 32'hffff_ffff};
    vecs[7]  = '{0, 0, 32'h0,         4'b0010, 4'b1101, 3, 1, 1, 1, 1, 32'h0000_ffff};
    vecs[8]  = '{0, 1, 32'hdead_beef, 4'b0000, 4'b1111, 4, 0, 0, 1, 1, 32'hdead_beef};
    vecs[9]  = '{0, 1, 32'h1234_5678, 4'b0001, 4'b1110, 3, 0, 1, 1, 0, 32'h0000_0000};
    vecs[10] = '{0, 1, 32'haaaa_aaaa, 4'b0000, 4'b1111, 4, 0, 0, 1, 0, 32'haaaa_aaaa};
    vecs[11] = '{0, 0, 32'h0,         4'b0100, 4'b1011, 3, 2, 1, 1, 2, 32'hffff_0000};
    vecs[12] = '{0, 1, 32'h5555_5555, 4'b0100, 4'b1111, 4, 0, 0, 1, 2, 32'h5555_5555};
    vecs[13] = '{1, 1, 32'h7777_7777, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 32'h0};

    #12 i_rst_n = 1;
    #1;
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_empty", 64'(o_empty), 1);
    chk("rst_full", 64'(o_full), 0);
    chk("rst_ready", 64'(o_wr_ready), 1);
    chk("rst_idx", 64'(o_wr_idx), 0);
    chk("rst_count", 64'(o_count), 0);
    chk("rst_data0", 64'(o_datas[0]), 0);

    foreach (vecs[k]) begin
      i_flush = vecs[k].fl; i_wr_valid = vecs[k].wv; i_wr_data = vecs[k].d; i_release = vecs[k].rel;
      #1;
      if (vecs[k].fl) chk("flush_ready", 64'(o_wr_ready), 0);
      @(posedge i_clk); #1;
      idle();
      #1;
      chk($sformatf("v%0d_valid", k), 64'(o_valid), 64'(vecs[k].ev));
      chk($sformatf("v%0d_count", k), 64'(o_count), 64'(vecs[k].ec));
      chk($sformatf("v%0d_idx", k), 64'(o_wr_idx), 64'(vecs[k].ei));
      chk($sformatf("v%0d_ready", k), 64'(o_wr_ready), 64'(vecs[k].er));
      chk($sformatf("v%0d_full", k), 64'(o_full), 64'(vecs[k].ec == N));
      chk($sformatf("v%0d_empty", k), 64'(o_empty), 64'(vecs[k].ec == 0));
      if (vecs[k].cd) chk($sformatf("v%0d_data", k), 64'(o_datas[vecs[k].cs]), 64'(vecs[k].ed));
    end

    i_wr_valid = 1; i_wr_data = 32'hcafe_0001;
    @(posedge i_clk); #1;
    chk("pre_rst_valid", 64'(o_valid), 64'b0001);
    i_wr_data = 32'hcafe_0002;
    #2 i_rst_n = 0;
    #1;
    chk("arst_valid", 64'(o_valid), 0);
    chk("arst_count", 64'(o_count), 0);
    chk("arst_empty", 64'(o_empty), 1);
    chk("arst_data0", 64'(o_datas[0]), 0);
    idle();
    @(negedge i_clk) i_rst_n = 1;
    @(posedge i_clk); #1;
    chk("post_rst_valid", 64'(o_valid), 0);
    chk("post_rst_data1", 64'(o_datas[1]), 0);

    m_valid = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
    for (int c = 0; c < 400; c++) begin
      logic acc;
      int idx;
      i_flush = $urandom_range(0, 31) == 0;
      i_wr_valid = $urandom_range(0, 3) != 0;
      i_wr_data = $urandom;
      i_release = $urandom_range(0, 2) == 0 ? N'($urandom) : '0;
      #1;
      idx = m_idx();
      acc = i_wr_valid && m_cnt() != N && !i_flush;
      chk("rnd_ready", 64'(o_wr_ready), 64'(m_cnt() != N && !i_flush));
      if (m_cnt() != N) chk("rnd_idx", 64'(o_wr_idx), 64'(idx));
      chk("rnd_valid", 64'(o_valid), 64'(m_valid));
      chk("rnd_count", 64'(o_count), 64'(m_cnt()));
      chk("rnd_full", 64'(o_full), 64'(m_cnt() == N));
      chk("rnd_empty", 64'(o_empty), 64'(m_cnt() == 0));
      for (int i = 0; i < N; i++) if (m_valid[i]) chk("rnd_data", 64'(o_datas[i]), 64'(m_data[i]));
      if (i_flush) m_valid = '0;
      else begin
        m_valid &= ~i_release;
        if (acc) begin
          m_valid[idx] = 1'b1;
          m_data[idx] = i_wr_data;
        end
      end
      @(posedge i_clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
